// File: rtl/aes_block_sequencer_if.sv
// Packet word bus shared by the input and output sides of the AES sequencer.
// The producer drives data/ctrl/wr and the consumer answers with rdy.
interface aes_block_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/aes_block_sequencer.sv
// AES block sequencer for the UDP packet pipeline.
// Module control headers and the first HDR_WORDS packet words pass through in
// clear. The remaining 64-bit payload words are paired into 128-bit blocks, run
// through an external multi-cycle AES core (start/done handshake) and the
// result is split back into 64-bit words. An odd trailing word is padded with
// zeros and only the upper result word is emitted, so packet length is kept.
module aes_block_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WORDS  = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    aes_block_sequencer_if.slave         in_bus,
    aes_block_sequencer_if.master        out_bus,
    input  logic [31:0]                  key,
    output logic                         aes_start,
    output logic [127:0]                 aes_state,
    output logic [127:0]                 aes_key,
    input  logic                         aes_done,
    input  logic [127:0]                 aes_out
);

    localparam int DEPTH_BITS = 2;
    localparam int DEPTH      = 4;
    localparam int WORD_W     = DATA_WIDTH + CTRL_WIDTH;
    localparam int CNT_W      = (HDR_WORDS < 2) ? 1 : $clog2(HDR_WORDS);
    localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = {CTRL_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_CTRL_HDR  = 3'd0,
        ST_HDR       = 3'd1,
        ST_GATHER_HI = 3'd2,
        ST_GATHER_LO = 3'd3,
        ST_START     = 3'd4,
        ST_WAIT      = 3'd5,
        ST_EMIT_HI   = 3'd6,
        ST_EMIT_LO   = 3'd7
    } state_t;

    // Input fall-through FIFO
    logic [WORD_W-1:0]     fifo_mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] fifo_wr_ptr_r;
    logic [DEPTH_BITS-1:0] fifo_rd_ptr_r;
    logic [DEPTH_BITS:0]   fifo_cnt_r;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  fifo_nearly_full_s;
    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic [CTRL_WIDTH-1:0] head_ctrl_s;

    // Sequencer state
    state_t                state_r;
    logic [CNT_W-1:0]      count_r;
    logic [DATA_WIDTH-1:0] hi_r;
    logic [DATA_WIDTH-1:0] lo_r;
    logic [CTRL_WIDTH-1:0] hi_ctrl_r;
    logic [CTRL_WIDTH-1:0] lo_ctrl_r;
    logic                  single_r;
    logic [127:0]          result_r;
    logic                  aes_start_r;
    logic [127:0]          aes_key_r;

    // Output word selection
    logic                  out_wr_s;
    logic [DATA_WIDTH-1:0] out_data_s;
    logic [CTRL_WIDTH-1:0] out_ctrl_s;

    assign fifo_empty_s       = (fifo_cnt_r == 3'd0);
    assign fifo_full_s        = (fifo_cnt_r == 3'd4);
    assign fifo_nearly_full_s = (fifo_cnt_r >= 3'd3);
    assign fifo_push_s        = in_bus.wr && !fifo_full_s;
    assign {head_ctrl_s, head_data_s} = fifo_mem_r[fifo_rd_ptr_r];

    assign in_bus.rdy   = !fifo_nearly_full_s;
    assign out_bus.wr   = out_wr_s;
    assign out_bus.data = out_data_s;
    assign out_bus.ctrl = out_ctrl_s;

    assign aes_start = aes_start_r;
    assign aes_state = {hi_r, lo_r};
    assign aes_key   = aes_key_r;

    // FIFO storage, pointers and occupancy; a write into a full FIFO is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {WORD_W{1'b0}};
            end
            fifo_wr_ptr_r <= 2'd0;
            fifo_rd_ptr_r <= 2'd0;
            fifo_cnt_r    <= 3'd0;
        end else begin
            if (fifo_push_s) begin
                fifo_mem_r[fifo_wr_ptr_r] <= {in_bus.ctrl, in_bus.data};
                fifo_wr_ptr_r             <= fifo_wr_ptr_r + 2'd1;
            end
            if (fifo_pop_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + 2'd1;
            end
            case ({fifo_push_s, fifo_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 3'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 3'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Output mux and FIFO pop: passthrough is fall-through, emits come from result.
    always_comb begin
        fifo_pop_s = 1'b0;
        out_wr_s   = 1'b0;
        out_data_s = DATA_ZERO;
        out_ctrl_s = CTRL_ZERO;
        case (state_r)
            ST_CTRL_HDR, ST_HDR: begin
                out_data_s = head_data_s;
                out_ctrl_s = head_ctrl_s;
                if (!fifo_empty_s && out_bus.rdy) begin
                    fifo_pop_s = 1'b1;
                    out_wr_s   = 1'b1;
                end else begin
                    fifo_pop_s = 1'b0;
                    out_wr_s   = 1'b0;
                end
            end
            ST_GATHER_HI, ST_GATHER_LO: begin
                fifo_pop_s = !fifo_empty_s;
            end
            ST_EMIT_HI: begin
                out_data_s = result_r[127:64];
                out_ctrl_s = single_r ? hi_ctrl_r : CTRL_ZERO;
                out_wr_s   = out_bus.rdy;
            end
            ST_EMIT_LO: begin
                out_data_s = result_r[63:0];
                out_ctrl_s = lo_ctrl_r;
                out_wr_s   = out_bus.rdy;
            end
            default: begin
                fifo_pop_s = 1'b0;
                out_wr_s   = 1'b0;
            end
        endcase
    end

    // Sequencer FSM: header counting, block gathering, core handshake and emit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_CTRL_HDR;
            count_r     <= {CNT_W{1'b0}};
            hi_r        <= DATA_ZERO;
            lo_r        <= DATA_ZERO;
            hi_ctrl_r   <= CTRL_ZERO;
            lo_ctrl_r   <= CTRL_ZERO;
            single_r    <= 1'b0;
            result_r    <= 128'd0;
            aes_start_r <= 1'b0;
            aes_key_r   <= 128'd0;
        end else begin
            case (state_r)
                ST_CTRL_HDR: begin
                    if (fifo_pop_s && head_ctrl_s == CTRL_ZERO) begin
                        count_r <= CNT_W'(1);
                        state_r <= (HDR_WORDS == 1) ? ST_GATHER_HI : ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (fifo_pop_s) begin
                        if (head_ctrl_s != CTRL_ZERO) begin
                            state_r <= ST_CTRL_HDR;
                        end else if (count_r == CNT_W'(HDR_WORDS - 1)) begin
                            state_r <= ST_GATHER_HI;
                        end else begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                end
                ST_GATHER_HI: begin
                    if (fifo_pop_s) begin
                        hi_r      <= head_data_s;
                        hi_ctrl_r <= head_ctrl_s;
                        if (head_ctrl_s != CTRL_ZERO) begin
                            // Odd trailing word: pad the low half and emit only hi later.
                            lo_r        <= DATA_ZERO;
                            lo_ctrl_r   <= CTRL_ZERO;
                            single_r    <= 1'b1;
                            aes_start_r <= 1'b1;
                            aes_key_r   <= {4{key}};
                            state_r     <= ST_START;
                        end else begin
                            state_r <= ST_GATHER_LO;
                        end
                    end
                end
                ST_GATHER_LO: begin
                    if (fifo_pop_s) begin
                        lo_r        <= head_data_s;
                        lo_ctrl_r   <= head_ctrl_s;
                        single_r    <= 1'b0;
                        aes_start_r <= 1'b1;
                        aes_key_r   <= {4{key}};
                        state_r     <= ST_START;
                    end
                end
                ST_START: begin
                    aes_start_r <= 1'b0;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (aes_done) begin
                        result_r <= aes_out;
                        state_r  <= ST_EMIT_HI;
                    end
                end
                ST_EMIT_HI: begin
                    if (out_bus.rdy) begin
                        state_r <= single_r ? ST_CTRL_HDR : ST_EMIT_LO;
                    end
                end
                ST_EMIT_LO: begin
                    if (out_bus.rdy) begin
                        state_r <= (lo_ctrl_r != CTRL_ZERO) ? ST_CTRL_HDR : ST_GATHER_HI;
                    end
                end
                default: begin
                    aes_start_r <= 1'b0;
                    state_r     <= ST_CTRL_HDR;
                end
            endcase
        end
    end

endmodule
